// File: rtl/spi_shift_engine_if.sv
// Host-side transfer interface of the SPI shift engine. The host issues a
// single-cycle start with tx_data; the engine reports busy, done and rx_data.
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;

    modport master (
        output start,
        output tx_data,
        input  busy,
        input  done,
        input  rx_data
    );

    modport slave (
        input  start,
        input  tx_data,
        output busy,
        output done,
        output rx_data
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: paces one DATA_WIDTH-bit, MSB-first transfer from
// the edges of an external half-rate spi_clk toggle, in any CPOL/CPHA mode.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_clk,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n,
    output logic [1:0]         fsm_state,
    spi_shift_engine_if.slave  host
);
    // Handshake: start is a one-cycle request, honoured only while idle and
    // not in the done cycle; busy covers acceptance+1 through done inclusive.

    localparam int CNT_W = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_EDGE  = CNT_W'(2 * DATA_WIDTH);
    localparam logic [CNT_W-1:0] FIRST_EDGE = CNT_W'(1);
    localparam logic SCLK_IDLE = (CPOL != 0);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SETUP    = 2'd1;
    localparam logic [1:0] S_TRANSFER = 2'd2;
    localparam logic [1:0] S_HOLD     = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  spi_clk_dly_q;
    logic                  tick_en_q;

    logic                  tick;
    logic [CNT_W-1:0]      edge_nxt;
    logic                  leading;

    always_comb begin
        // The delayed copy must load once after reset before edges count.
        tick     = tick_en_q && (spi_clk != spi_clk_dly_q);
        edge_nxt = edge_cnt_q + FIRST_EDGE;
        leading  = edge_nxt[0];

        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (host.start && !done_q) begin
                    tx_shift_d = host.tx_data;
                    rx_shift_d = '0;
                    edge_cnt_d = '0;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_TRANSFER;
                end
            end
            S_TRANSFER: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_nxt;
                    // Sample and shift sit on opposite edges; which one is
                    // which depends on CPHA.
                    if (leading) begin
                        if (CPHA == 0) begin
                            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                        end else if (edge_nxt != FIRST_EDGE) begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (CPHA != 0) begin
                            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
                        end else if (edge_nxt != LAST_EDGE) begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (edge_nxt == LAST_EDGE) begin
                        state_d = S_HOLD;
                    end
                end
            end
            default: begin
                if (tick) begin
                    cs_n_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            edge_cnt_q    <= '0;
            sclk_q        <= SCLK_IDLE;
            cs_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spi_clk_dly_q <= 1'b0;
            tick_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            edge_cnt_q    <= edge_cnt_d;
            sclk_q        <= sclk_d;
            cs_n_q        <= cs_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            spi_clk_dly_q <= spi_clk;
            tick_en_q     <= 1'b1;
        end
    end

    assign sclk         = sclk_q;
    assign mosi         = tx_shift_q[DATA_WIDTH-1];
    assign cs_n         = cs_n_q;
    assign fsm_state    = state_q;
    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.rx_data = rx_data_q;
endmodule
